// File: rtl/fwd_hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard_pkg
//   Shared definitions for the forwarding / hazard scoreboard block:
//   default register-address width, the "read from register file" select
//   code, the multi-cycle scoreboard state encoding and a constant clog2
//   helper used to size select and countdown fields.
// ---------------------------------------------------------------------------
package fwd_hazard_scoreboard_pkg;

    // Default architectural register address width (32 registers).
    localparam int RA_W_DEF = 5;

    // Forward-select code meaning "no bypass, use the register file value".
    localparam int SEL_REGFILE = 0;

    // Multi-cycle unit scoreboard states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mc_state_e;

    // Ceiling log2 for sizing fields. Never returns less than 1 so that a
    // field sized with it is always a legal, non-empty vector.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage : fwd_hazard_scoreboard_pkg

// File: rtl/fwd_hazard_scoreboard_src_sel.sv
// ---------------------------------------------------------------------------
// fwd_src_sel
//   Forward-select priority encoder for one EXE-stage source operand.
//   Scans the forwarding stages from nearest (index 0, MEM) to oldest
//   (index NUM_STG-1, WB); the nearest enabled stage whose destination
//   matches the source wins. Register 0 never forwards.
//
// Ports
//   forward_en  in   1              0 forces the register-file select
//   src         in   RA_W           EXE-stage source register
//   dst_stg     in   NUM_STG*RA_W   destination per forwarding stage
//   wb_en_stg   in   NUM_STG        write enable per forwarding stage
//   sel         out  SEL_W          0 = regfile, k = stage NUM_STG-k
// ---------------------------------------------------------------------------
module fwd_src_sel
    import fwd_hazard_scoreboard_pkg::*;
#(
    parameter int RA_W    = RA_W_DEF,
    parameter int NUM_STG = 2,
    parameter int SEL_W   = 2
) (
    input  logic                    forward_en,
    input  logic [RA_W-1:0]         src,
    input  logic [NUM_STG*RA_W-1:0] dst_stg,
    input  logic [NUM_STG-1:0]      wb_en_stg,
    output logic [SEL_W-1:0]        sel
);

    // Walk oldest-to-nearest so that a nearer hit overwrites an older one;
    // the final value is therefore the lowest matching stage index.
    always_comb begin
        sel = SEL_W'(SEL_REGFILE);
        if (forward_en && (src != '0)) begin
            for (int i = NUM_STG - 1; i >= 0; i--) begin
                if (wb_en_stg[i] && (dst_stg[i*RA_W +: RA_W] == src)) begin
                    sel = SEL_W'(NUM_STG - i);
                end
            end
        end
    end

endmodule : fwd_src_sel

// File: rtl/fwd_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_hazard_scoreboard
//   Forwarding and hazard unit sitting between ID/EXE and the stall path.
//   - Per-source forward selects over NUM_STG writeback stages.
//   - ID-stage stall: load-use hazards and RAW against the non-pipelined
//     multi-cycle unit (MUL/DIV), whose in-flight destination is tracked by
//     an IDLE/BUSY countdown scoreboard.
//   - forward_en=0 falls back to full interlock: any in-flight RAW stalls.
//   - Saturating counter of stalled cycles for performance monitoring.
//
// Ports
//   clk           in   1               rising-edge clock
//   rst           in   1               asynchronous active-high reset
//   forward_en    in   1               1 = forwarding, 0 = interlock only
//   freeze        in   1               pipeline frozen; state holds
//   src_id        in   NUM_SRC*RA_W    ID-stage source registers
//   src_id_vld    in   NUM_SRC         ID source actually read
//   src_exe       in   NUM_SRC*RA_W    EXE-stage source registers
//   dst_exe       in   RA_W            EXE destination
//   wb_en_exe     in   1               EXE instruction writes a register
//   mem_read_exe  in   1               EXE instruction is a load
//   mc_issue_exe  in   1               EXE instruction issues to MUL/DIV
//   dst_stg       in   NUM_STG*RA_W    destination per forwarding stage
//   wb_en_stg     in   NUM_STG         write enable per forwarding stage
//   sel_fwd       out  NUM_SRC*SEL_W   per-source forward select
//   stall_id      out  1               hold PC/IF/ID, bubble into EXE
//   mc_busy       out  1               multi-cycle op in flight
//   mc_dst        out  RA_W            destination of in-flight op
//   mc_wb_vld     out  1               multi-cycle result writes back now
//   mc_overrun    out  1               sticky: issue while busy
//   stall_cnt     out  CNT_W           saturating stalled-cycle count
// ---------------------------------------------------------------------------
module fwd_hazard_scoreboard
    import fwd_hazard_scoreboard_pkg::*;
#(
    parameter int   RA_W    = RA_W_DEF,
    parameter int   NUM_SRC = 3,
    parameter int   NUM_STG = 2,
    parameter int   MC_LAT  = 4,
    parameter int   CNT_W   = 16,
    localparam int  SEL_W   = clog2_f(NUM_STG + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    forward_en,
    input  logic                    freeze,
    input  logic [NUM_SRC*RA_W-1:0] src_id,
    input  logic [NUM_SRC-1:0]      src_id_vld,
    input  logic [NUM_SRC*RA_W-1:0] src_exe,
    input  logic [RA_W-1:0]         dst_exe,
    input  logic                    wb_en_exe,
    input  logic                    mem_read_exe,
    input  logic                    mc_issue_exe,
    input  logic [NUM_STG*RA_W-1:0] dst_stg,
    input  logic [NUM_STG-1:0]      wb_en_stg,
    output logic [NUM_SRC*SEL_W-1:0] sel_fwd,
    output logic                    stall_id,
    output logic                    mc_busy,
    output logic [RA_W-1:0]         mc_dst,
    output logic                    mc_wb_vld,
    output logic                    mc_overrun,
    output logic [CNT_W-1:0]        stall_cnt
);

    // Countdown width: holds MC_LAT-1 down to 0.
    localparam int MCC_W = clog2_f(MC_LAT);
    localparam logic [MCC_W-1:0] MC_RELOAD = MCC_W'(MC_LAT - 1);

    mc_state_e         state_q, state_d;
    logic [MCC_W-1:0]  mc_cnt_q, mc_cnt_d;
    logic [RA_W-1:0]   mc_dst_q, mc_dst_d;
    logic              overrun_q, overrun_d;
    logic              wb_vld;
    logic              stall;

    // ---------------- forward selects (combinational) ----------------
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_sel #(
            .RA_W    (RA_W),
            .NUM_STG (NUM_STG),
            .SEL_W   (SEL_W)
        ) u_src_sel (
            .forward_en (forward_en),
            .src        (src_exe[s*RA_W +: RA_W]),
            .dst_stg    (dst_stg),
            .wb_en_stg  (wb_en_stg),
            .sel        (sel_fwd[s*SEL_W +: SEL_W])
        );
    end

    // ---------------- ID-stage stall (combinational) ----------------
    // In forwarding mode only a load in EXE cannot be bypassed in time; the
    // writeback stages are covered by sel_fwd. In interlock mode every
    // pending writer (EXE or any forwarding stage) must drain first. The
    // multi-cycle destination blocks in both modes.
    always_comb begin
        stall = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_id_vld[s] && (src_id[s*RA_W +: RA_W] != '0)) begin
                if (forward_en) begin
                    if (mem_read_exe && wb_en_exe &&
                        (src_id[s*RA_W +: RA_W] == dst_exe)) begin
                        stall = 1'b1;
                    end
                end else begin
                    if (wb_en_exe && (src_id[s*RA_W +: RA_W] == dst_exe)) begin
                        stall = 1'b1;
                    end
                    for (int i = 0; i < NUM_STG; i++) begin
                        if (wb_en_stg[i] &&
                            (dst_stg[i*RA_W +: RA_W] == src_id[s*RA_W +: RA_W])) begin
                            stall = 1'b1;
                        end
                    end
                end
                if ((state_q == ST_BUSY) &&
                    (src_id[s*RA_W +: RA_W] == mc_dst_q)) begin
                    stall = 1'b1;
                end
            end
        end
    end

    // ---------------- multi-cycle scoreboard next state ----------------
    // Completion (count 0) may coincide with a new issue: the unit frees
    // and is immediately reloaded. An issue while still counting is a
    // protocol violation; it is flagged and otherwise ignored so the op in
    // flight completes undisturbed.
    always_comb begin
        state_d   = state_q;
        mc_cnt_d  = mc_cnt_q;
        mc_dst_d  = mc_dst_q;
        overrun_d = overrun_q;
        wb_vld    = 1'b0;
        if (!freeze) begin
            case (state_q)
                ST_IDLE: begin
                    if (mc_issue_exe) begin
                        state_d  = ST_BUSY;
                        mc_dst_d = dst_exe;
                        mc_cnt_d = MC_RELOAD;
                    end
                end
                ST_BUSY: begin
                    if (mc_cnt_q != '0) begin
                        mc_cnt_d = mc_cnt_q - MCC_W'(1);
                        if (mc_issue_exe) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        wb_vld = 1'b1;
                        if (mc_issue_exe) begin
                            mc_dst_d = dst_exe;
                            mc_cnt_d = MC_RELOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mc_cnt_q  <= '0;
            mc_dst_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_cnt_q  <= mc_cnt_d;
            mc_dst_q  <= mc_dst_d;
            overrun_q <= overrun_d;
        end
    end

    // ---------------- stall performance counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !freeze && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign stall_id   = stall;
    assign mc_busy    = (state_q == ST_BUSY);
    assign mc_dst     = mc_dst_q;
    assign mc_wb_vld  = wb_vld;
    assign mc_overrun = overrun_q;

endmodule : fwd_hazard_scoreboard

// File: tb/tb_fwd_hazard_scoreboard.sv
module tb_fwd_hazard_scoreboard;

    localparam int RA_W    = 5;
    localparam int NUM_SRC = 3;
    localparam int NUM_STG = 2;
    localparam int MC_LAT  = 4;
    localparam int CNT_W   = 5;
    localparam int SEL_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     forward_en;
    logic                     freeze;
    logic [NUM_SRC*RA_W-1:0]  src_id;
    logic [NUM_SRC-1:0]       src_id_vld;
    logic [NUM_SRC*RA_W-1:0]  src_exe;
    logic [RA_W-1:0]          dst_exe;
    logic                     wb_en_exe;
    logic                     mem_read_exe;
    logic                     mc_issue_exe;
    logic [NUM_STG*RA_W-1:0]  dst_stg;
    logic [NUM_STG-1:0]       wb_en_stg;
    logic [NUM_SRC*SEL_W-1:0] sel_fwd;
    logic                     stall_id;
    logic                     mc_busy;
    logic [RA_W-1:0]          mc_dst;
    logic                     mc_wb_vld;
    logic                     mc_overrun;
    logic [CNT_W-1:0]         stall_cnt;

    fwd_hazard_scoreboard #(
        .RA_W(RA_W), .NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG),
        .MC_LAT(MC_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .freeze(freeze),
        .src_id(src_id), .src_id_vld(src_id_vld), .src_exe(src_exe),
        .dst_exe(dst_exe), .wb_en_exe(wb_en_exe), .mem_read_exe(mem_read_exe),
        .mc_issue_exe(mc_issue_exe), .dst_stg(dst_stg), .wb_en_stg(wb_en_stg),
        .sel_fwd(sel_fwd), .stall_id(stall_id), .mc_busy(mc_busy),
        .mc_dst(mc_dst), .mc_wb_vld(mc_wb_vld), .mc_overrun(mc_overrun),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The multi-cycle unit is modelled as "an op with m_rem cycles left
    // before its writeback cycle".
    bit m_busy;
    int m_dst;
    int m_rem;
    bit m_ovr;
    int m_scnt;

    function automatic int f_src_id(int s);  return int'(src_id[s*RA_W +: RA_W]);  endfunction
    function automatic int f_src_exe(int s); return int'(src_exe[s*RA_W +: RA_W]); endfunction
    function automatic int f_dst_stg(int i); return int'(dst_stg[i*RA_W +: RA_W]); endfunction

    function automatic int model_sel(int s);
        if (!forward_en) return 0;
        for (int i = 0; i < NUM_STG; i++)
            if (wb_en_stg[i] && f_dst_stg(i) != 0 && f_dst_stg(i) == f_src_exe(s))
                return NUM_STG - i;
        return 0;
    endfunction

    function automatic bit model_stall();
        for (int s = 0; s < NUM_SRC; s++) begin
            int r = f_src_id(s);
            if (!src_id_vld[s] || r == 0) continue;
            if (m_busy && r == m_dst) return 1'b1;
            if (forward_en) begin
                if (mem_read_exe && wb_en_exe && r == int'(dst_exe)) return 1'b1;
            end else begin
                if (wb_en_exe && r == int'(dst_exe)) return 1'b1;
                for (int i = 0; i < NUM_STG; i++)
                    if (wb_en_stg[i] && f_dst_stg(i) == r) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_dst = 0; m_rem = 0; m_ovr = 0; m_scnt = 0;
    endtask

    // Advance the model by one clock edge using the inputs of the cycle that ends.
    task automatic model_clock();
        if (freeze) return;
        if (model_stall() && m_scnt < CNT_MAX) m_scnt++;
        if (!m_busy) begin
            if (mc_issue_exe) begin m_busy = 1; m_dst = int'(dst_exe); m_rem = MC_LAT - 1; end
        end else if (m_rem > 0) begin
            if (mc_issue_exe) m_ovr = 1;
            m_rem--;
        end else if (mc_issue_exe) begin
            m_dst = int'(dst_exe); m_rem = MC_LAT - 1;
        end else begin
            m_busy = 0;
        end
    endtask

    typedef struct {
        logic [NUM_SRC*SEL_W-1:0] sel;
        logic                     stall;
        logic                     busy;
        logic [RA_W-1:0]          dst;
        logic                     wbv;
        logic                     ovr;
        logic [CNT_W-1:0]         scnt;
    } exp_t;

    exp_t exp_q[$];

    task automatic push_exp();
        exp_t e;
        for (int s = 0; s < NUM_SRC; s++) e.sel[s*SEL_W +: SEL_W] = SEL_W'(model_sel(s));
        e.stall = model_stall();
        e.busy  = m_busy;
        e.dst   = RA_W'(m_dst);
        e.wbv   = m_busy && (m_rem == 0) && !freeze;
        e.ovr   = m_ovr;
        e.scnt  = CNT_W'(m_scnt);
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("mon_sel_fwd",    int'(sel_fwd),    int'(mon_e.sel));
            chk("mon_stall_id",   int'(stall_id),   int'(mon_e.stall));
            chk("mon_mc_busy",    int'(mc_busy),    int'(mon_e.busy));
            chk("mon_mc_dst",     int'(mc_dst),     int'(mon_e.dst));
            chk("mon_mc_wb_vld",  int'(mc_wb_vld),  int'(mon_e.wbv));
            chk("mon_mc_overrun", int'(mc_overrun), int'(mon_e.ovr));
            chk("mon_stall_cnt",  int'(stall_cnt),  int'(mon_e.scnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        forward_en = 1; freeze = 0; src_id = '0; src_id_vld = '0; src_exe = '0;
        dst_exe = '0; wb_en_exe = 0; mem_read_exe = 0; mc_issue_exe = 0;
        dst_stg = '0; wb_en_stg = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        if (!rst) model_clock();
        #1;
    endtask

    task automatic go();
        push_exp();
        #2;
    endtask

    task automatic do_reset();
        next_cycle(); idle_inputs(); rst = 1; model_reset(); go();
        next_cycle(); rst = 0; go();
    endtask

    task automatic issue(input int d);
        next_cycle(); idle_inputs(); mc_issue_exe = 1; dst_exe = RA_W'(d); go();
    endtask

    task automatic read_id(input int r);
        idle_inputs(); src_id[0 +: RA_W] = RA_W'(r); src_id_vld = 3'b001;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 1000000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();

        // Reset state
        next_cycle(); go();
        chk("rst_busy", int'(mc_busy), 0);
        chk("rst_dst", int'(mc_dst), 0);
        chk("rst_wb_vld", int'(mc_wb_vld), 0);
        chk("rst_overrun", int'(mc_overrun), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        next_cycle(); rst = 0; go();

        // 1: nearest stage wins; WB only when MEM disabled
        next_cycle(); idle_inputs();
        src_exe[0 +: RA_W] = 5'd3; dst_stg = {5'd3, 5'd3}; wb_en_stg = 2'b11; go();
        chk("t1_sel_mem", int'(sel_fwd[1:0]), 2);
        next_cycle(); wb_en_stg = 2'b10; go();
        chk("t1_sel_wb", int'(sel_fwd[1:0]), 1);

        // 2: register zero never forwards; interlock mode
        next_cycle(); idle_inputs(); wb_en_stg = 2'b11; go();
        chk("t2_sel_zero", int'(sel_fwd), 0);
        next_cycle(); idle_inputs(); forward_en = 0;
        src_exe[0 +: RA_W] = 5'd3; dst_stg[0 +: RA_W] = 5'd3; wb_en_stg = 2'b01;
        src_id[0 +: RA_W] = 5'd3; src_id_vld = 3'b001; go();
        chk("t2_sel_nofwd", int'(sel_fwd), 0);
        chk("t2_stall_interlock", int'(stall_id), 1);

        // 3: load-use
        do_reset();
        next_cycle(); idle_inputs(); mem_read_exe = 1; wb_en_exe = 1; dst_exe = 5'd5;
        src_id[1*RA_W +: RA_W] = 5'd5; src_id_vld = 3'b010; go();
        chk("t3_stall", int'(stall_id), 1);
        chk("t3_cnt_before", int'(stall_cnt), 0);
        next_cycle(); idle_inputs(); go();
        chk("t3_stall_clear", int'(stall_id), 0);
        chk("t3_cnt_after", int'(stall_cnt), 1);

        // 4a: MC RAW stalls t1..t4, writeback pulse at t4
        do_reset();
        issue(7);
        for (int k = 1; k <= 5; k++) begin
            next_cycle(); read_id(7); go();
            chk($sformatf("t4_stall_t%0d", k), int'(stall_id), (k <= 4) ? 1 : 0);
            chk($sformatf("t4_wbv_t%0d", k), int'(mc_wb_vld), (k == 4) ? 1 : 0);
        end
        chk("t4_busy_done", int'(mc_busy), 0);

        // 4b: freeze at t2 moves the pulse to t5
        do_reset();
        issue(7);
        for (int k = 1; k <= 6; k++) begin
            next_cycle(); read_id(7); freeze = (k == 2); go();
            chk($sformatf("t4f_wbv_t%0d", k), int'(mc_wb_vld), (k == 5) ? 1 : 0);
        end

        // 5a: back-to-back at completion is legal
        do_reset();
        issue(4);
        for (int k = 1; k <= 3; k++) begin next_cycle(); idle_inputs(); go(); end
        issue(6);
        chk("t5_wbv_t4", int'(mc_wb_vld), 1);
        next_cycle(); idle_inputs(); go();
        chk("t5_busy_t5", int'(mc_busy), 1);
        chk("t5_dst_t5", int'(mc_dst), 6);
        chk("t5_no_overrun", int'(mc_overrun), 0);

        // 5b: re-issue while counting -> sticky overrun, original op intact
        do_reset();
        issue(9);
        next_cycle(); idle_inputs(); go();
        issue(10);
        next_cycle(); idle_inputs(); go();
        chk("t5_overrun", int'(mc_overrun), 1);
        chk("t5_dst_kept", int'(mc_dst), 9);
        next_cycle(); idle_inputs(); go();
        chk("t5_wbv_orig", int'(mc_wb_vld), 1);
        next_cycle(); idle_inputs(); go();
        chk("t5_busy_end", int'(mc_busy), 0);
        chk("t5_overrun_sticky", int'(mc_overrun), 1);

        // 6: async reset mid-op
        do_reset();
        issue(7);
        next_cycle(); read_id(7); go();
        next_cycle(); read_id(7); rst = 1; model_reset(); go();
        chk("t6_busy", int'(mc_busy), 0);
        chk("t6_cnt", int'(stall_cnt), 0);
        chk("t6_stall", int'(stall_id), 0);
        next_cycle(); rst = 0; go();
        for (int k = 0; k < 6; k++) begin
            next_cycle(); idle_inputs(); go();
            chk($sformatf("t6_no_pulse_%0d", k), int'(mc_wb_vld), 0);
        end

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (rst) rst = 0;
            else if ($urandom_range(0, 99) == 0) begin rst = 1; model_reset(); end
            forward_en   = ($urandom_range(0, 9) < 8);
            freeze       = ($urandom_range(0, 99) < 15);
            for (int s = 0; s < NUM_SRC; s++) begin
                src_id[s*RA_W +: RA_W]  = RA_W'($urandom_range(0, 4));
                src_exe[s*RA_W +: RA_W] = RA_W'($urandom_range(0, 4));
            end
            src_id_vld   = NUM_SRC'($urandom);
            dst_exe      = RA_W'($urandom_range(0, 4));
            wb_en_exe    = 1'($urandom);
            mem_read_exe = ($urandom_range(0, 3) == 0);
            mc_issue_exe = ($urandom_range(0, 99) < 20);
            for (int i = 0; i < NUM_STG; i++)
                dst_stg[i*RA_W +: RA_W] = RA_W'($urandom_range(0, 4));
            wb_en_stg    = NUM_STG'($urandom);
            go();
        end

        // Drain the scoreboard
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #8;
        chk("drain_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_fwd_hazard_scoreboard
